// File: rtl/strhw_msg_feeder_if.sv
// Handshake/bus bundle for strhw_msg_feeder: the message byte stream on one
// side and the Streebog control-logic initiator signals on the other.
// state_i encoding: 0 CLEAR, 1 BUSY, 2 READY, 3 DONE.
interface strhw_msg_feeder_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [7:0]   in_data_i;
    logic         in_last_i;
    logic         in_empty_i;
    logic         hash_size_i;
    logic         trg_o;
    logic [1:0]   state_i;
    logic [511:0] block_o;
    logic [6:0]   block_size_o;
    logic         hash_size_o;
    logic [511:0] hash_i;
    logic [511:0] hash_o;
    logic         hash_valid_o;

    // Feeder side
    modport master (
        input  in_valid_i, in_data_i, in_last_i, in_empty_i, hash_size_i, state_i, hash_i,
        output in_ready_o, trg_o, block_o, block_size_o, hash_size_o, hash_o, hash_valid_o
    );

    // Stream source / control logic side
    modport slave (
        output in_valid_i, in_data_i, in_last_i, in_empty_i, hash_size_i, state_i, hash_i,
        input  in_ready_o, trg_o, block_o, block_size_o, hash_size_o, hash_o, hash_valid_o
    );
endinterface

// File: rtl/strhw_msg_feeder.sv
// Streebog message feeder: packs a byte stream into 512-bit blocks, sequences
// the control logic (CLEAR -> BUSY -> READY/DONE -> CLEAR) and returns the hash.
// Optional: define STRHW_FEEDER_MSB_FIRST_EN to place the first byte in the MSB.
module strhw_msg_feeder (
    input logic               clk_i,
    input logic               rst_ni,
    strhw_msg_feeder_if.master bus
);
    localparam logic [1:0] CtlClear = 2'd0;
    localparam logic [1:0] CtlBusy  = 2'd1;
    localparam logic [1:0] CtlReady = 2'd2;
    localparam logic [1:0] CtlDone  = 2'd3;

    typedef enum logic [2:0] {
        StFill, StArm, StIssue, StWaitBusy, StWaitEnd, StRestart, StWaitClear
    } state_e;

    state_e       state_q, state_d;
    logic [6:0]   count_q, count_d;
    logic [1:0]   clr_cnt_q, clr_cnt_d;     // consecutive CLEAR samples, saturating
    logic         first_q, first_d;         // next issue is the first block of a message
    logic         started_q, started_d;     // first beat of the message accepted
    logic         last_q, last_d;           // current block was closed by in_last_i
    logic         tail_q, tail_d;           // size-0 block owed after an aligned message
    logic [511:0] block_q, block_d;
    logic         hash_size_q, hash_size_d;
    logic [511:0] hash_q, hash_d;
    logic         hash_valid_q, hash_valid_d;
    logic         trg_q, trg_d;
    logic         in_ready_q, in_ready_d;

    logic accept;
    logic clear_ok;

    assign accept   = bus.in_valid_i && in_ready_q;
    // Current sample plus at least one prior consecutive sample of CLEAR
    assign clear_ok = (bus.state_i == CtlClear) && (clr_cnt_q != 2'd0);

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        first_d      = first_q;
        started_d    = started_q;
        last_d       = last_q;
        tail_d       = tail_q;
        block_d      = block_q;
        hash_size_d  = hash_size_q;
        hash_d       = hash_q;
        hash_valid_d = 1'b0;
        trg_d        = 1'b0;

        if (bus.state_i == CtlClear) begin
            clr_cnt_d = (clr_cnt_q == 2'd3) ? 2'd3 : clr_cnt_q + 2'd1;
        end else begin
            clr_cnt_d = 2'd0;
        end

        unique case (state_q)
            StFill: begin
                if (tail_q) begin
                    tail_d  = 1'b0;
                    state_d = StArm;
                end else if (accept) begin
                    if (!started_q) begin
                        started_d   = 1'b1;
                        hash_size_d = bus.hash_size_i;
                    end
                    if (!(bus.in_last_i && bus.in_empty_i)) begin
`ifdef STRHW_FEEDER_MSB_FIRST_EN
                        block_d[9'd504 - {count_q[5:0], 3'b000} +: 8] = bus.in_data_i;
`else
                        block_d[{count_q[5:0], 3'b000} +: 8] = bus.in_data_i;
`endif
                        count_d = count_q + 7'd1;
                    end
                    if ((count_d == 7'd64) || bus.in_last_i) begin
                        last_d  = bus.in_last_i;
                        state_d = StArm;
                    end
                end
            end
            StArm: begin
                if (first_q ? clear_ok : (bus.state_i == CtlReady)) begin
                    trg_d   = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                first_d = 1'b0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (bus.state_i == CtlBusy) state_d = StWaitEnd;
            end
            StWaitEnd: begin
                if (bus.state_i == CtlReady) begin
                    block_d = '0;
                    count_d = 7'd0;
                    // Control logic only finalizes on size < 64
                    tail_d  = last_q && (count_q == 7'd64);
                    state_d = StFill;
                end else if (bus.state_i == CtlDone) begin
                    hash_d       = bus.hash_i;
                    hash_valid_d = 1'b1;
                    state_d      = StRestart;
                end
            end
            StRestart: begin
                if (bus.state_i == CtlDone) begin
                    trg_d   = 1'b1;
                    state_d = StWaitClear;
                end
            end
            StWaitClear: begin
                if (bus.state_i == CtlClear) begin
                    block_d   = '0;
                    count_d   = 7'd0;
                    first_d   = 1'b1;
                    started_d = 1'b0;
                    last_d    = 1'b0;
                    tail_d    = 1'b0;
                    state_d   = StFill;
                end
            end
            default: state_d = StFill;
        endcase

        in_ready_d = (state_d == StFill) && !tail_d;
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StFill;
            count_q      <= 7'd0;
            clr_cnt_q    <= 2'd0;
            first_q      <= 1'b1;
            started_q    <= 1'b0;
            last_q       <= 1'b0;
            tail_q       <= 1'b0;
            block_q      <= '0;
            hash_size_q  <= 1'b0;
            hash_q       <= '0;
            hash_valid_q <= 1'b0;
            trg_q        <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            clr_cnt_q    <= clr_cnt_d;
            first_q      <= first_d;
            started_q    <= started_d;
            last_q       <= last_d;
            tail_q       <= tail_d;
            block_q      <= block_d;
            hash_size_q  <= hash_size_d;
            hash_q       <= hash_d;
            hash_valid_q <= hash_valid_d;
            trg_q        <= trg_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready_o   = in_ready_q;
    assign bus.trg_o        = trg_q;
    assign bus.block_o      = block_q;
    assign bus.block_size_o = count_q;
    assign bus.hash_size_o  = hash_size_q;
    assign bus.hash_o       = hash_q;
    assign bus.hash_valid_o = hash_valid_q;
endmodule

// File: tb/tb_strhw_msg_feeder.sv
// Bench for strhw_msg_feeder: a small control-logic model answers triggers,
// expected blocks/hashes are queued and compared as the DUT produces them.
module tb_strhw_msg_feeder;
    localparam logic [1:0] CTL_CLEAR = 2'd0;
    localparam logic [1:0] CTL_BUSY  = 2'd1;
    localparam logic [1:0] CTL_READY = 2'd2;
    localparam logic [1:0] CTL_DONE  = 2'd3;

    typedef struct {
        logic [6:0]   size;
        logic [511:0] blk;
        logic         hs;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b1;
    strhw_msg_feeder_if bus ();

    strhw_msg_feeder dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int hv_cnt = 0;
    exp_t exp_q[$];
    logic [511:0] exp_hash[$];

    // Control-logic model
    logic [1:0]   ctl_state;
    int           busy_left;
    int           clr_run;
    logic [6:0]   issued_size;
    logic [511:0] nh;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctl_state   <= CTL_CLEAR;
            busy_left   <= 0;
            clr_run     <= 0;
            issued_size <= 7'd0;
            bus.hash_i  <= '0;
        end else begin
            clr_run <= (ctl_state == CTL_CLEAR) ? clr_run + 1 : 0;
            case (ctl_state)
                CTL_CLEAR, CTL_READY: if (bus.trg_o) begin
                    ctl_state   <= CTL_BUSY;
                    busy_left   <= 3;
                    issued_size <= bus.block_size_o;
                end
                CTL_BUSY: begin
                    if (busy_left > 1) busy_left <= busy_left - 1;
                    else if (issued_size < 7'd64) begin
                        for (int i = 0; i < 16; i++) nh[32*i +: 32] = $urandom;
                        bus.hash_i <= nh;
                        exp_hash.push_back(nh);
                        ctl_state <= CTL_DONE;
                    end else ctl_state <= CTL_READY;
                end
                default: if (bus.trg_o) ctl_state <= CTL_CLEAR;
            endcase
        end
    end
    assign bus.state_i = ctl_state;

    // Output monitor / scoreboard
    exp_t         mon_e;
    logic [511:0] mon_h;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (ctl_state == CTL_BUSY) begin
                checks++;
                if (bus.in_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ready in_ready_o=%b want 0", bus.in_ready_o);
                end
            end
            if (bus.trg_o && ctl_state != CTL_DONE) begin
                issue_cnt++;
                if (ctl_state == CTL_CLEAR) begin
                    checks++;
                    if (clr_run < 2) begin
                        errors++;
                        $display("FAIL arm_clear clear_cycles=%0d want >=2", clr_run);
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected size=%0d want no issue", bus.block_size_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.block_size_o !== mon_e.size || bus.block_o !== mon_e.blk ||
                        bus.hash_size_o !== mon_e.hs) begin
                        errors++;
                        $display("FAIL issue_block size=%0d hs=%b blk=%h want size=%0d hs=%b blk=%h",
                                 bus.block_size_o, bus.hash_size_o, bus.block_o,
                                 mon_e.size, mon_e.hs, mon_e.blk);
                    end
                end
            end
            if (bus.hash_valid_o) begin
                hv_cnt++;
                checks++;
                if (exp_hash.size() == 0) begin
                    errors++;
                    $display("FAIL hash_unexpected hash_o=%h want no pulse", bus.hash_o);
                end else begin
                    mon_h = exp_hash.pop_front();
                    if (bus.hash_o !== mon_h) begin
                        errors++;
                        $display("FAIL hash_value hash_o=%h want %h", bus.hash_o, mon_h);
                    end
                end
            end
        end
    end

    // Drive one beat and wait (bounded) for acceptance
    task automatic drive_beat(input logic [7:0] d, input logic last, input logic empty,
                              input logic hs, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_i);
            bus.in_valid_i  = 1'b1;
            bus.in_data_i   = d;
            bus.in_last_i   = last;
            bus.in_empty_i  = empty;
            bus.hash_size_i = hs;
            if (bus.in_ready_o === 1'b1) begin
                @(posedge clk_i);
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Send n bytes (base+i); expected blocks follow the packing rules
    task automatic send_msg(input int n, input logic hs, input bit empty_tail,
                            input bit no_last, input int base);
        logic [511:0] blk = '0;
        int cnt = 0;
        bit ok;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'((base + i) & 255);
            drive_beat(d, (i == n - 1) && !empty_tail && !no_last, 1'b0, hs, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL beat_accept byte=%0d accepted=0 want 1", i);
                return;
            end
`ifdef STRHW_FEEDER_MSB_FIRST_EN
            blk[511 - 8*cnt -: 8] = d;
`else
            blk[8*cnt +: 8] = d;
`endif
            cnt++;
            if (cnt == 64) begin
                exp_q.push_back('{7'd64, blk, hs});
                blk = '0;
                cnt = 0;
            end
        end
        if (!no_last) begin
            if (empty_tail || n == 0) begin
                drive_beat(8'hA5, 1'b1, 1'b1, hs, ok);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL empty_accept accepted=0 want 1");
                end
            end
            exp_q.push_back('{7'(cnt), blk, hs});
        end
        @(negedge clk_i);
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        bus.in_empty_i = 1'b0;
    endtask

    task automatic wait_hv(input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            if (hv_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_msg(input string name, input int n, input logic hs, input bit empty_tail,
                           input int base, input int want_issues);
        int hv0 = hv_cnt;
        int is0 = issue_cnt;
        bit ok;
        send_msg(n, hs, empty_tail, 1'b0, base);
        wait_hv(hv0 + 1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done hash_valid=0 want 1 (timeout)", name);
        end
        repeat (10) @(negedge clk_i);
        checks++;
        if (hv_cnt - hv0 != 1) begin
            errors++;
            $display("FAIL %s_hv_count got=%0d want 1", name, hv_cnt - hv0);
        end
        checks++;
        if (issue_cnt - is0 != want_issues) begin
            errors++;
            $display("FAIL %s_issues got=%0d want %0d", name, issue_cnt - is0, want_issues);
        end
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready_o, bus.trg_o, bus.block_o, bus.block_size_o, bus.hash_size_o,
             bus.hash_o, bus.hash_valid_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs in_ready=%b trg=%b size=%0d hv=%b want all 0",
                     bus.in_ready_o, bus.trg_o, bus.block_size_o, bus.hash_valid_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready in_ready_o=%b want 1", bus.in_ready_o);
        end
    endtask

    task automatic test_short_63();  run_msg("short63", 63, 1'b0, 1'b0, 0, 1);     endtask
    task automatic test_aligned_64(); run_msg("aligned64", 64, 1'b0, 1'b0, 7, 2);  endtask
    task automatic test_empty();     run_msg("empty", 0, 1'b0, 1'b1, 0, 1);        endtask
    task automatic test_long_130();  run_msg("long130", 130, 1'b1, 1'b0, 200, 3);  endtask
    task automatic test_aligned_empty_beat(); run_msg("align_eb", 64, 1'b1, 1'b1, 90, 2); endtask

    task automatic test_back_to_back();
        int hv0 = hv_cnt;
        bit ok;
        send_msg(5, 1'b1, 1'b0, 1'b0, 33);
        send_msg(70, 1'b0, 1'b0, 1'b0, 120);
        wait_hv(hv0 + 2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_done hashes=%0d want 2 (timeout)", hv_cnt - hv0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        send_msg(64, 1'b0, 1'b0, 1'b1, 64);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk_i);
            if (ctl_state == CTL_BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_busy reached=0 want 1");
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready_o, bus.trg_o, bus.block_o, bus.block_size_o, bus.hash_size_o,
             bus.hash_o, bus.hash_valid_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs trg=%b size=%0d hash_nz=%b want all 0",
                     bus.trg_o, bus.block_size_o, |bus.hash_o);
        end
        exp_q.delete();
        exp_hash.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_msg("after_reset", 3, 1'b0, 1'b0, 250, 1);
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = 8'h00;
        bus.in_last_i   = 1'b0;
        bus.in_empty_i  = 1'b0;
        bus.hash_size_i = 1'b0;
        test_reset();
        test_short_63();
        test_aligned_64();
        test_empty();
        test_long_130();
        test_aligned_empty_beat();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0 || exp_hash.size() != 0) begin
            errors++;
            $display("FAIL leftover blocks=%0d hashes=%0d want 0 0", exp_q.size(), exp_hash.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/strhw_msg_feeder.md
# strhw_msg_feeder

Byte-stream front end for the Streebog core. Packs an incoming message byte stream into 512-bit blocks and drives the control logic's initiator interface: `trg`, `state`, `block`, `block_size`, `hash_size`, `hash`. Sequences the control logic through CLEAR → BUSY → READY/DONE → CLEAR, returns the final hash with a one-cycle valid pulse, then rearms for the next message.

## Interface
- No parameters. Block width 512, size field 7 bits, `state_t` and `uint512`/`uint7` come from `strhw_common_types`.
- `clk_i` in 1: clock, all logic on rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1: message beat valid.
- `in_ready_o` out 1: feeder accepts a beat when `in_valid_i && in_ready_o`.
- `in_data_i` in 8: message byte.
- `in_last_i` in 1: beat is the last of the message.
- `in_empty_i` in 1: only meaningful with `in_last_i`. The byte is ignored, which is how an empty or exactly-aligned tail is signalled.
- `hash_size_i` in 1: 0 selects 512-bit, 1 selects 256-bit. Sampled on the first accepted beat of a message.
- `trg_o` out 1: one-cycle trigger to the control logic.
- `state_i` in `state_t`: control logic state (CLEAR/BUSY/READY/DONE).
- `block_o` out 512: packed block. Unused bytes are zero.
- `block_size_o` out 7: valid bytes in `block_o`, range 0..64.
- `hash_size_o` out 1: latched hash size.
- `hash_i` in 512: control logic hash output.
- `hash_o` out 512: captured hash.
- `hash_valid_o` out 1: one-cycle pulse when `hash_o` updates.

## Operation
- States: FILL, ARM, ISSUE, WAIT_BUSY, WAIT_END, RESTART, WAIT_CLEAR.
- **FILL**
  - `in_ready_o`=1. Byte k of the block (k = byte count 0..63) is written to `block_o[8k+7:8k]`.
  - The count increments per accepted non-empty byte.
  - Block closes when count reaches 64 or on an accepted `in_last_i` beat. Then go to ARM.
- **ARM**
  - Requires `state_i`==CLEAR for ≥2 consecutive cycles on the first block of a message. The count includes cycles spent in FILL.
  - Requires `state_i`==READY on later blocks.
  - When satisfied, go to ISSUE.
- **ISSUE**: `trg_o`=1 for exactly one cycle, then go to WAIT_BUSY.
- **WAIT_BUSY**: wait for `state_i`==BUSY, then go to WAIT_END.
- **WAIT_END**
  - On READY: clear `block_o` and the count, set `tail_pending` if needed, go to FILL.
  - On DONE: capture `hash_i`, pulse `hash_valid_o`, go to RESTART.
- **RESTART**
  - Wait for `state_i`==DONE, pulse `trg_o` once, go to WAIT_CLEAR.
  - The RESTART trigger returns the control logic to CLEAR.
- **WAIT_CLEAR**: wait for `state_i`==CLEAR, then go to FILL with a new message.
- `in_ready_o`=0 in every state except FILL. The feeder is single-buffered.
- **Aligned tail**
  - A message ending exactly on a 64-byte boundary (`in_last_i` on byte 64, or count already 64) issues the full block with size 64.
  - It then issues a second block with size 0 and all-zero data, without consuming further beats. The control logic finalizes only when size < 64.
- **Empty beat**
  - `in_last_i && in_empty_i` closes the block without writing data.
  - With count 0 this yields block size 0, which is the empty message case.
- `hash_size_o` is latched on the first beat and held for the whole message.
- `block_o`, `block_size_o` and `hash_size_o` are stable from the ISSUE cycle until WAIT_END exits.
- `hash_o` holds its value until the next capture.

## Timing
- Reset values:
  - all outputs 0 (`in_ready_o`=0, `trg_o`=0, `block_o`=0, `block_size_o`=0, `hash_size_o`=0, `hash_o`=0, `hash_valid_o`=0);
  - state=FILL, count=0, clear-cycle counter=0;
  - `in_ready_o` rises in the first cycle after reset release.
- Outputs are registered. `trg_o` asserts in the cycle after ARM conditions are met.
- Fill takes 1 byte per cycle. A 64-byte block needs 64 accepted beats.
- `hash_valid_o` asserts the cycle after `state_i`==DONE is first sampled.
- Reset mid-operation: all state is lost and the partial block is discarded. The control logic's own reset is owned by the integrator.

## Configuration
- `STRHW_FEEDER_MSB_FIRST_EN` defined: byte k is placed at `block_o[511-8k:504-8k]`, i.e. the first byte lands in the most significant byte.
- Not defined: byte k is placed at `block_o[8k+7:8k]`, i.e. little-endian packing.

## Test plan
- 63 bytes 0x00..0x3E, `in_last_i` on the 63rd → one ISSUE with `block_size_o`=63, bytes 63 of `block_o` = 0; `hash_valid_o` pulses once.
- 64 bytes with `in_last_i` on the 64th → two ISSUEs: size 64, then size 0 with `block_o`=0; one `hash_valid_o`.
- Empty message: single beat with `in_last_i`=1, `in_empty_i`=1 → one ISSUE, size 0, `block_o`=0.
- 130-byte message, `hash_size_i`=1 → sizes 64, 64, 2; `hash_size_o`=1 throughout; `hash_o` equals the `hash_i` value present at DONE.
- Back-to-back messages → second-message trigger only after ≥2 cycles of CLEAR following the RESTART `trg_o`; `in_ready_o`=0 during BUSY.
- Reset asserted in WAIT_END → all outputs 0 immediately; after release the next message starts from count 0.
